// File: rtl/param_loader_pkg.sv
// Shared definitions for the parameter frame loader and the pulse generator:
// FSM states, reply codes, field offsets and the power-on pulse programme.
package param_loader_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      PAYLOAD = 3'd1,
      CSUM    = 3'd2,
      CHECK   = 3'd3,
      ACK     = 3'd4
   } state_t;

   localparam logic [7:0] ACK_OK        = 8'h06;
   localparam logic [7:0] ACK_BAD       = 8'h15;
   localparam int         PAYLOAD_BYTES = 18;

   localparam logic [31:0] PER_RST      = 32'd65536;
   localparam logic [15:0] P1WID_RST    = 16'd30;
   localparam logic [15:0] DEL_RST      = 16'd200;
   localparam logic [15:0] P2WID_RST    = 16'd30;
   localparam logic [7:0]  NUT_W_RST    = 8'd50;
   localparam logic [15:0] NUT_D_RST    = 16'd300;
   localparam logic [7:0]  CP_RST       = 8'd3;
   localparam logic [7:0]  P_BL_RST     = 8'd50;
   localparam logic [15:0] P_BL_OFF_RST = 16'd100;
   localparam logic        BL_RST       = 1'b1;

   // Big-endian byte offsets of each field inside the payload
   localparam int OFS_PER      = 0;
   localparam int OFS_P1WID    = 4;
   localparam int OFS_DEL      = 6;
   localparam int OFS_P2WID    = 8;
   localparam int OFS_NUT_W    = 10;
   localparam int OFS_NUT_D    = 11;
   localparam int OFS_CP       = 13;
   localparam int OFS_P_BL     = 14;
   localparam int OFS_P_BL_OFF = 15;
   localparam int OFS_BL       = 17;

endpackage

// File: rtl/param_loader.sv
// Collects checksummed parameter frames from the UART byte stream into a shadow
// buffer and commits the whole pulse programme in one cycle with a load strobe.
//
// state   | meaning
// HUNT    | discard bytes until the frame header
// PAYLOAD | store 18 payload bytes into the shadow buffer
// CSUM    | wait for the checksum byte
// CHECK   | commit or reject the frame (single cycle)
// ACK     | hold the reply byte until the transmitter takes it
module param_loader
   import param_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 500000,
   parameter logic [7:0]  HEADER         = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  ack_data,
   output logic        ack_valid,
   input  logic        ack_ready,
   output logic [31:0] per,
   output logic [15:0] p1wid,
   output logic [15:0] del,
   output logic [15:0] p2wid,
   output logic [7:0]  nut_w,
   output logic [15:0] nut_d,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        bl,
   output logic        rxd,
   output logic        frame_err
);

   localparam int             GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES);

   state_t             state, state_nxt;
   logic [4:0]         idx;
   logic [7:0]         sum;
   logic [GAP_W-1:0]   gap_cnt;
   logic [7:0]         shadow [PAYLOAD_BYTES];
   logic               store_byte, add_byte, commit, reject, timeout, ack_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= HUNT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      store_byte = 1'b0;
      add_byte   = 1'b0;
      commit     = 1'b0;
      reject     = 1'b0;
      timeout    = 1'b0;
      ack_done   = 1'b0;
      case (state)
         HUNT: begin
            if (rx_valid && rx_data == HEADER) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            if (rx_valid) begin
               store_byte = 1'b1;
               add_byte   = 1'b1;
               if (idx == 5'(PAYLOAD_BYTES - 1)) state_nxt = CSUM;
            end else if (gap_cnt == GAP_MAX) begin
               timeout   = 1'b1;
               state_nxt = HUNT;
            end
         end
         CSUM: begin
            if (rx_valid) begin
               add_byte  = 1'b1;
               state_nxt = CHECK;
            end else if (gap_cnt == GAP_MAX) begin
               timeout   = 1'b1;
               state_nxt = HUNT;
            end
         end
         CHECK: begin
            if (sum == 8'h00) commit = 1'b1;
            else              reject = 1'b1;
            state_nxt = ACK;
         end
         ACK: begin
            if (ack_valid && ack_ready) begin
               ack_done  = 1'b1;
               state_nxt = HUNT;
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   // Shadow buffer, running checksum and inter-byte gap counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx     <= '0;
         sum     <= '0;
         gap_cnt <= '0;
         for (int i = 0; i < PAYLOAD_BYTES; i++) shadow[i] <= '0;
      end else begin
         if (state == HUNT) begin
            idx <= '0;
            sum <= '0;
         end
         if (store_byte) begin
            shadow[idx] <= rx_data;
            idx         <= idx + 5'd1;
         end
         if (add_byte) sum <= sum + rx_data;
         if (state == PAYLOAD || state == CSUM) begin
            if (rx_valid)                gap_cnt <= '0;
            else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         per       <= PER_RST;
         p1wid     <= P1WID_RST;
         del       <= DEL_RST;
         p2wid     <= P2WID_RST;
         nut_w     <= NUT_W_RST;
         nut_d     <= NUT_D_RST;
         cp        <= CP_RST;
         p_bl      <= P_BL_RST;
         p_bl_off  <= P_BL_OFF_RST;
         bl        <= BL_RST;
         rxd       <= 1'b0;
         frame_err <= 1'b0;
         ack_data  <= 8'h00;
         ack_valid <= 1'b0;
      end else begin
         rxd       <= commit;
         frame_err <= reject | timeout;
         if (commit) begin
            per      <= {shadow[OFS_PER], shadow[OFS_PER+1], shadow[OFS_PER+2], shadow[OFS_PER+3]};
            p1wid    <= {shadow[OFS_P1WID], shadow[OFS_P1WID+1]};
            del      <= {shadow[OFS_DEL], shadow[OFS_DEL+1]};
            p2wid    <= {shadow[OFS_P2WID], shadow[OFS_P2WID+1]};
            nut_w    <= shadow[OFS_NUT_W];
            nut_d    <= {shadow[OFS_NUT_D], shadow[OFS_NUT_D+1]};
            cp       <= shadow[OFS_CP];
            p_bl     <= shadow[OFS_P_BL];
            p_bl_off <= {shadow[OFS_P_BL_OFF], shadow[OFS_P_BL_OFF+1]};
            bl       <= shadow[OFS_BL][0];
         end
         if (commit || reject) begin
            ack_valid <= 1'b1;
            ack_data  <= commit ? ACK_OK : ACK_BAD;
         end else if (ack_done) begin
            ack_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: good/bad frames, gap timeout, header bytes
// inside the payload, reply back-pressure and reset in the middle of a frame.
module tb_param_loader;
   import param_loader_pkg::*;

   localparam int unsigned TMO = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  ack_data;
   logic        ack_valid;
   logic        ack_ready;
   logic [31:0] per;
   logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
   logic [7:0]  nut_w, cp, p_bl;
   logic        bl, rxd, frame_err;

   int tests = 0;
   int fails = 0;
   int rxd_cnt = 0;
   int r0;
   int n;

   logic [7:0] frame_a [PAYLOAD_BYTES] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h1E, 8'h00, 8'hC8, 8'h00,
                                           8'h1E, 8'h32, 8'h01, 8'h2C, 8'h01, 8'h32, 8'h00, 8'h64, 8'h01};
   logic [7:0] frame_b [PAYLOAD_BYTES] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                                           8'hBC, 8'hDE, 8'hF0, 8'h12, 8'h07, 8'h34, 8'h55, 8'h66, 8'hFE};

   param_loader #(.TIMEOUT_CYCLES(TMO), .HEADER(8'hA5)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .ack_data  (ack_data),
      .ack_valid (ack_valid),
      .ack_ready (ack_ready),
      .per       (per),
      .p1wid     (p1wid),
      .del       (del),
      .p2wid     (p2wid),
      .nut_w     (nut_w),
      .nut_d     (nut_d),
      .cp        (cp),
      .p_bl      (p_bl),
      .p_bl_off  (p_bl_off),
      .bl        (bl),
      .rxd       (rxd),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rxd === 1'b1) rxd_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the byte is sampled on the next rising edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Returns at the falling edge just after edge E (checksum sampled).
   task automatic send_frame(input logic [7:0] p [PAYLOAD_BYTES], input logic [7:0] adj,
                             input int gap_after, input int gap_len);
      logic [7:0] s;
      logic [7:0] c;
      s = 8'h00;
      send_byte(8'hA5);
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         send_byte(p[i]);
         s = s + p[i];
         if (i == gap_after) repeat (gap_len) @(negedge clk);
      end
      c = 8'h00 - s;
      c = c + adj;
      send_byte(c);
   endtask

   task automatic check_frame_a(input string tag);
      chk({tag, "_per"},      per,             32'h0001_0000);
      chk({tag, "_p1wid"},    32'(p1wid),      32'd30);
      chk({tag, "_del"},      32'(del),        32'd200);
      chk({tag, "_p2wid"},    32'(p2wid),      32'd30);
      chk({tag, "_nut_w"},    32'(nut_w),      32'd50);
      chk({tag, "_nut_d"},    32'(nut_d),      32'd300);
      chk({tag, "_cp"},       32'(cp),         32'd1);
      chk({tag, "_p_bl"},     32'(p_bl),       32'd50);
      chk({tag, "_p_bl_off"}, 32'(p_bl_off),   32'd100);
      chk({tag, "_bl"},       32'(bl),         32'd1);
   endtask

   initial begin
      reset     = 1'b0;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      ack_ready = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_per",      per,              32'd65536);
      chk("rst_p1wid",    32'(p1wid),       32'd30);
      chk("rst_del",      32'(del),         32'd200);
      chk("rst_p2wid",    32'(p2wid),       32'd30);
      chk("rst_nut_w",    32'(nut_w),       32'd50);
      chk("rst_nut_d",    32'(nut_d),       32'd300);
      chk("rst_cp",       32'(cp),          32'd3);
      chk("rst_p_bl",     32'(p_bl),        32'd50);
      chk("rst_p_bl_off", 32'(p_bl_off),    32'd100);
      chk("rst_bl",       32'(bl),          32'd1);
      chk("rst_rxd",      32'(rxd),         32'd0);
      chk("rst_ferr",     32'(frame_err),   32'd0);
      chk("rst_ackv",     32'(ack_valid),   32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Good frame: checksum byte is 8'h04
      send_frame(frame_a, 8'h00, -1, 0);
      chk("good_rxd_E",   32'(rxd),         32'd0);
      chk("good_cp_E",    32'(cp),          32'd3);
      @(negedge clk);
      chk("good_rxd_E1",  32'(rxd),         32'd1);
      chk("good_ackv",    32'(ack_valid),   32'd1);
      chk("good_ackd",    32'(ack_data),    32'h06);
      check_frame_a("good");
      @(negedge clk);
      chk("good_rxd_E2",  32'(rxd),         32'd0);
      chk("good_ack_done", 32'(ack_valid),  32'd0);
      chk("good_rxd_cnt", 32'(rxd_cnt),     32'd1);

      // Bad checksum
      r0 = rxd_cnt;
      send_frame(frame_b, 8'h01, -1, 0);
      @(negedge clk);
      chk("bad_ferr",     32'(frame_err),   32'd1);
      chk("bad_rxd",      32'(rxd),         32'd0);
      chk("bad_ackv",     32'(ack_valid),   32'd1);
      chk("bad_ackd",     32'(ack_data),    32'h15);
      @(negedge clk);
      chk("bad_ferr_off", 32'(frame_err),   32'd0);
      check_frame_a("bad");
      chk("bad_no_rxd",   32'(rxd_cnt),     32'(r0));

      // Timeout after header plus 5 payload bytes
      send_byte(8'hA5);
      for (int i = 0; i < 5; i++) send_byte(frame_b[i]);
      n = 0;
      while (frame_err !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_latency",  32'(n),           32'(TMO + 1));
      chk("tmo_ackv",     32'(ack_valid),   32'd0);
      chk("tmo_state",    32'(dut.state),   32'(HUNT));
      @(negedge clk);
      chk("tmo_ferr_off", 32'(frame_err),   32'd0);
      check_frame_a("tmo");
      chk("tmo_no_rxd",   32'(rxd_cnt),     32'(r0));

      // Header bytes as data, with a gap of exactly the limit after payload byte 6
      send_frame(frame_b, 8'h00, 6, TMO);
      @(negedge clk);
      chk("hdr_rxd",      32'(rxd),         32'd1);
      chk("hdr_ferr",     32'(frame_err),   32'd0);
      chk("hdr_per",      per,              32'hA5A5_A5A5);
      chk("hdr_p1wid",    32'(p1wid),       32'h1234);
      chk("hdr_del",      32'(del),         32'h5678);
      chk("hdr_p2wid",    32'(p2wid),       32'h9ABC);
      chk("hdr_nut_w",    32'(nut_w),       32'hDE);
      chk("hdr_nut_d",    32'(nut_d),       32'hF012);
      chk("hdr_cp",       32'(cp),          32'h07);
      chk("hdr_p_bl",     32'(p_bl),        32'h34);
      chk("hdr_p_bl_off", 32'(p_bl_off),    32'h5566);
      chk("hdr_bl",       32'(bl),          32'd0);
      @(negedge clk);

      // Reply back-pressure with a stray header during ACK
      ack_ready = 1'b0;
      r0 = rxd_cnt;
      send_frame(frame_a, 8'h00, -1, 0);
      @(negedge clk);
      chk("bp_rxd",       32'(rxd),         32'd1);
      chk("bp_cp",        32'(cp),          32'd1);
      repeat (50) @(negedge clk);
      send_byte(8'hA5);
      repeat (49) @(negedge clk);
      chk("bp_ackv_held", 32'(ack_valid),   32'd1);
      chk("bp_ackd",      32'(ack_data),    32'h06);
      chk("bp_state",     32'(dut.state),   32'(ACK));
      chk("bp_one_rxd",   32'(rxd_cnt),     32'(r0 + 1));
      ack_ready = 1'b1;
      @(negedge clk);
      chk("bp_ackv_clr",  32'(ack_valid),   32'd0);
      chk("bp_hunt",      32'(dut.state),   32'(HUNT));

      // Reset after 10 payload bytes; the remainder must not form a frame
      send_byte(8'hA5);
      for (int i = 0; i < 10; i++) send_byte(frame_b[i]);
      reset = 1'b0;
      #2;
      chk("mid_rst_per",  per,              32'd65536);
      chk("mid_rst_cp",   32'(cp),          32'd3);
      chk("mid_rst_bl",   32'(bl),          32'd1);
      chk("mid_rst_state", 32'(dut.state),  32'(HUNT));
      @(negedge clk);
      reset = 1'b1;
      r0 = rxd_cnt;
      for (int i = 10; i < PAYLOAD_BYTES; i++) send_byte(frame_a[i]);
      send_byte(8'h04);
      repeat (3) @(negedge clk);
      chk("mid_rst_no_rxd", 32'(rxd_cnt),   32'(r0));
      chk("mid_rst_cp2",  32'(cp),          32'd3);
      chk("mid_rst_ackv", 32'(ack_valid),   32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_loader.md
# param_loader

Receives parameter frames from the host UART byte stream, checks them, and updates the full pulse-programme register set in one step. It then produces the one-cycle load strobe that the pulse generator samples on its `rxd` input. The block sits between the UART receiver and the pulse generator, in the 50 MHz `clk` domain. A bad or truncated frame never changes any output.

## Interface
- `TIMEOUT_CYCLES`, 500000: maximum allowed gap, in `clk` cycles, between bytes inside a frame (10 ms at 50 MHz).
- `HEADER`, 8'hA5: frame start byte.
- `clk`  in  1  50 MHz system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `ack_data`  out  8  reply byte: 8'h06 for a good frame, 8'h15 for a bad checksum.
- `ack_valid`  out  1  reply pending; held until accepted.
- `ack_ready`  in  1  UART transmitter accepts `ack_data` when `ack_valid` and `ack_ready` are both high.
- `per`  out  32  period. Reset value 65536.
- `p1wid`  out  16  pulse 1 width. Reset value 30.
- `del`  out  16  inter-pulse delay. Reset value 200.
- `p2wid`  out  16  pulse 2 / CPMG pulse width. Reset value 30.
- `nut_w`  out  8  nutation pulse width. Reset value 50.
- `nut_d`  out  16  nutation pulse delay. Reset value 300.
- `cp`  out  8  mode: 0 = CW, 1 = Hahn echo, N > 1 = CPMG with N pulses. Reset value 3.
- `p_bl`  out  8  block-open start. Reset value 50.
- `p_bl_off`  out  16  block-open end. Reset value 100.
- `bl`  out  1  blocking enable. Reset value 1.
- `rxd`  out  1  load strobe. Reset value 0.
- `frame_err`  out  1  one-cycle error strobe. Reset value 0.

## Operation
- Frame layout: `HEADER`, then 18 payload bytes, then 1 checksum byte.
- Payload is big-endian, with fields in this order:
  - `per` (4 bytes), `p1wid` (2), `del` (2), `p2wid` (2)
  - `nut_w` (1), `nut_d` (2), `cp` (1), `p_bl` (1)
  - `p_bl_off` (2), `bl` (1 byte; only bit 0 is used, bits 7:1 are ignored).
- Checksum rule: the 8-bit sum of all 18 payload bytes plus the checksum byte must equal 0 (mod 256).
- Payload bytes are written into an 18-byte shadow buffer. Outputs are updated only at commit, all fields in the same cycle.
- States:
  - **HUNT**: discard every byte except `HEADER`. On `HEADER`, go to PAYLOAD with index = 0 and sum = 0.
  - **PAYLOAD**: store each byte at shadow[index], add it to sum, increment index. After byte 17, go to CSUM.
  - **CSUM**: on the next byte, add it to sum and go to CHECK.
  - **CHECK**: single cycle.
    - If sum == 0: copy shadow to outputs, pulse `rxd`, load `ack_data` = 8'h06.
    - Otherwise: leave outputs unchanged, pulse `frame_err`, load `ack_data` = 8'h15.
    - In both cases set `ack_valid` and go to ACK.
  - **ACK**: stay until `ack_valid` and `ack_ready` are both high. In that cycle clear `ack_valid` and go to HUNT. Bytes arriving during ACK are dropped.
- A `HEADER` value appearing inside PAYLOAD or CSUM is treated as data, not as a new frame start.
- Timeout (PAYLOAD or CSUM only):
  - The gap counter clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, go to HUNT, send no ack, and leave outputs unchanged.
- Reset mid-frame: all state clears immediately, outputs return to their reset values, and the partial frame is lost.

## Timing
- Let E be the `clk` edge that samples the checksum byte.
- At edge E+1, parameter outputs, `ack_data` and `ack_valid` all update.
  - `rxd` (or `frame_err`) is high for exactly the one cycle between E+1 and E+2.
- `ack_valid` may be accepted as early as edge E+2. The first byte of the next frame is accepted in HUNT from the following cycle.
- Total latency from the checksum byte to the parameter update is 1 cycle. Parameter outputs are stable at all other times.
- `rxd` never stays high for more than 1 cycle, and never pulses for a rejected frame.
- Gap counter:
  - Width is `$clog2(TIMEOUT_CYCLES + 1)`; it saturates and does not wrap.
  - The timeout fires on the cycle the counter equals `TIMEOUT_CYCLES` with no `rx_valid` present.
  - If `rx_valid` arrives in that same cycle, the byte is accepted and the timeout does not fire.

## Structure
- Shared package contents:
  - State enum (HUNT, PAYLOAD, CSUM, CHECK, ACK).
  - Constants `ACK_OK` = 8'h06, `ACK_BAD` = 8'h15, `PAYLOAD_BYTES` = 18.
  - All parameter reset defaults. The pulse generator uses the same defaults, so they live in one place.
  - Byte offset constant of each field within the payload.
- No sub-module. The FSM, shadow buffer, checksum and gap counter all stay in the single module.

## Test plan
- **Good frame**: A5, 00 01 00 00 | 00 1E | 00 C8 | 00 1E | 32 | 01 2C | 01 | 32 | 00 64 | 01, checksum chosen so the sum is 0. Expect all fields to match the bytes, `rxd` high for 1 cycle at E+1, and `ack_data` = 06.
- **Bad checksum**: same frame with the checksum +1. Expect outputs unchanged, `frame_err` high for 1 cycle, `ack_data` = 15, and `rxd` never high.
- **Timeout**: A5 plus 5 payload bytes, then no input for 500000 cycles. Expect `frame_err` at the cycle where the counter reaches the limit, no ack, and a following good frame accepted normally.
- **Header as data**: good frame with `per` = A5 A5 A5 A5. Expect `per` = 32'hA5A5A5A5.
- **Ack back-pressure**: hold `ack_ready` low for 100 cycles after a good frame, and send A5 during that wait. Expect `ack_valid` held and the A5 dropped. Then raise `ack_ready`: expect one handshake and return to HUNT.
- **Reset mid-frame**: assert `reset` low after 10 payload bytes. Expect outputs at their reset values (`per` = 65536, `cp` = 3, `bl` = 1) and the state at HUNT.
